// File: rtl/wb_pkg.sv
// Shared opcode constants, entry kinds and instruction classification for write-back.
// No logic of its own; wb_classify is purely combinational.
// No flow control here.
package wb_pkg;

    localparam logic [5:0] OP_JMP = 6'b100001;
    localparam logic [5:0] OP_BR  = 6'b100000;
    localparam logic [5:0] OP_LDI = 6'b010001;

    // K_RD marks a redirect (taken branch or jump) entry
    typedef enum logic {
        K_WR = 1'b0,
        K_RD = 1'b1
    } kind_e;

    function automatic logic [1:0] wb_classify(input logic [5:0] op, input logic ife);
        logic is_wr;
        logic is_redirect;
        is_wr       = (op[5:4] == 2'b00) || (op == OP_LDI);
        is_redirect = (op == OP_JMP) || ((op == OP_BR) && ife);
        return {is_wr, is_redirect};
    endfunction

endpackage

// File: rtl/wb_fwd_mux.sv
// Newest-match search of pending register writes for decode forwarding.
// Combinational, zero cycles.
// No flow control; pure lookup over the current buffer contents.
module wb_fwd_mux
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
) (
    input  logic [DEPTH-1:0]         vld,
    input  logic [DEPTH-1:0]         kind_rd,
    input  logic [DEPTH*REG_AW-1:0]  rds,
    input  logic [DEPTH*DATA_W-1:0]  dats,
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH)-1:0] tail,
    input  logic [REG_AW-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;
    logic          done;

    // Walk from the newest slot (tail-1) back towards head; the first match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        done     = 1'b0;
        idx      = tail;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail - PW'(i + 1);
            if (!done && !fwd_hit) begin
                if (vld[idx] && !kind_rd[idx] && (fwd_addr != '0) &&
                    (rds[idx*REG_AW +: REG_AW] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = dats[idx*DATA_W +: DATA_W];
                end
                if (idx == head) begin
                    done = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_commit_buf.sv
// In-order write-back commit buffer: drains register writes, issues PC redirects, forwards pending values.
// Latency one cycle from accept to strobe when empty; one accept and one pop per cycle.
// in_ready low when full or during a redirect pulse; WR head stalls while rf_grant is low.
module wb_commit_buf
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic                       in_ife,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       rf_grant,
    output logic                       reg_we,
    output logic [REG_AW-1:0]          reg_waddr,
    output logic [DATA_W-1:0]          reg_wdata,
    output logic                       pc_update,
    output logic [DATA_W-1:0]          pc_new,
    input  logic [REG_AW-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  ent_vld;
    kind_e             ent_kind [DEPTH];
    logic [REG_AW-1:0] ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_dat  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] occ;

    logic          head_wr;
    logic          head_rd;
    logic [1:0]    cls;
    logic          do_push;
    logic          do_pop;

    logic [DEPTH-1:0]        kind_rd_mask;
    logic [DEPTH*REG_AW-1:0] rd_flat;
    logic [DEPTH*DATA_W-1:0] dat_flat;

    assign head_wr = ent_vld[head] && (ent_kind[head] == K_WR);
    assign head_rd = ent_vld[head] && (ent_kind[head] == K_RD);

    assign pc_update = head_rd;
    assign pc_new    = head_rd ? ent_dat[head] : '0;
    assign reg_we    = head_wr && rf_grant;
    assign reg_waddr = reg_we ? ent_rd[head]  : '0;
    assign reg_wdata = reg_we ? ent_dat[head] : '0;

    // Registered state only, so rf_grant never reaches in_ready.
    assign in_ready  = (occ < CW'(DEPTH)) && !head_rd;
    assign occupancy = occ;

    // NOPs, not-taken branches and writes to r0 complete the handshake but are dropped.
    assign cls     = wb_classify(in_op[5:0], in_ife);
    assign do_push = in_valid && in_ready && ((cls[1] && (in_rd != '0)) || cls[0]);
    assign do_pop  = reg_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld <= '0;
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
        end else if (head_rd) begin
            // Redirect retires and squashes everything younger; no push can coincide.
            ent_vld <= '0;
            head    <= tail;
            occ     <= '0;
        end else begin
            if (do_push) begin
                ent_vld[tail]  <= 1'b1;
                ent_kind[tail] <= cls[0] ? K_RD : K_WR;
                ent_rd[tail]   <= in_rd;
                ent_dat[tail]  <= in_data;
                tail           <= tail + 1'b1;
            end
            if (do_pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (do_push && !do_pop) begin
                occ <= occ + 1'b1;
            end else if (do_pop && !do_push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_comb begin
        kind_rd_mask = '0;
        rd_flat      = '0;
        dat_flat     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kind_rd_mask[i]              = (ent_kind[i] == K_RD);
            rd_flat[i*REG_AW +: REG_AW]  = ent_rd[i];
            dat_flat[i*DATA_W +: DATA_W] = ent_dat[i];
        end
    end

    wb_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_fwd_mux (
        .vld      (ent_vld),
        .kind_rd  (kind_rd_mask),
        .rds      (rd_flat),
        .dats     (dat_flat),
        .head     (head),
        .tail     (tail),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

endmodule

// File: tb/tb_wb_commit_buf.sv
// Scoreboard bench for wb_commit_buf: expected writes and redirects are queued at stimulus time
// and a negedge monitor pops and compares them whenever the DUT strobes.
module tb_wb_commit_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic        in_ife = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic        rf_grant = 1'b0;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        pc_update;
    logic [31:0] pc_new;
    logic [4:0]  fwd_addr = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr [$];
    logic [31:0] exp_pc [$];
    wr_t         mon_e;
    logic [31:0] mon_pc;

    wb_commit_buf #(.DATA_W(32), .REG_AW(5), .OP_W(6), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ife    (in_ife),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .rf_grant  (rf_grant),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .pc_update (pc_update),
        .pc_new    (pc_new),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [5:0] op, input logic ife, input logic [4:0] rd, input logic [31:0] dat);
        logic r;
        int   n;
        in_valid = 1'b1;
        in_op    = op;
        in_ife   = ife;
        in_rd    = rd;
        in_data  = dat;
        r = 1'b0;
        n = 0;
        while (!r && n <= 100) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: op 0x%0h not accepted in %0d cycles", op, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (occupancy != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_occupancy", occupancy, 0);
        step();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we) begin
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got rd %0d data 0x%0h, required no write", reg_waddr, reg_wdata);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", reg_waddr, mon_e.a);
                    chk("wr_data", reg_wdata, mon_e.d);
                end
            end else begin
                chk("idle_waddr", reg_waddr, 0);
                chk("idle_wdata", reg_wdata, 0);
            end
            if (pc_update) begin
                if (exp_pc.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_redirect: got pc_new 0x%0h, required no redirect", pc_new);
                end else begin
                    mon_pc = exp_pc.pop_front();
                    chk("pc_new", pc_new, mon_pc);
                end
            end else begin
                chk("idle_pc_new", pc_new, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_pc_update", pc_update, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        step();

        // Back-to-back writes with the port always granted
        rf_grant = 1'b1;
        exp_wr.push_back('{5'd3, 32'h11});
        exp_wr.push_back('{5'd4, 32'h22});
        fork
            begin
                send(6'b000010, 1'b0, 5'd3, 32'h11);
                send(6'b000010, 1'b0, 5'd4, 32'h22);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                chk("lat_reg_we", reg_we, 1);
                chk("lat_waddr", reg_waddr, 3);
                chk("lat_occupancy", occupancy, 1);
            end
        join
        @(negedge clk);
        chk("b2b_occupancy", occupancy, 1);
        chk("b2b_waddr", reg_waddr, 4);
        wait_idle();

        // Fill with the port blocked, then drain
        rf_grant = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            exp_wr.push_back('{5'(i), 32'h100 + 32'(i)});
        end
        for (int i = 1; i <= 4; i++) begin
            send(6'b000010, 1'b0, 5'(i), 32'h100 + 32'(i));
        end
        @(negedge clk);
        chk("full_occupancy", occupancy, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_reg_we", reg_we, 0);
        step();
        fork
            send(6'b000010, 1'b0, 5'd5, 32'h105);
            begin
                repeat (2) @(posedge clk);
                #1 rf_grant = 1'b1;
            end
        join
        @(negedge clk);
        chk("refill_occupancy", occupancy, 3);
        step();
        wait_idle();

        // Forwarding picks the newest pending write
        rf_grant = 1'b0;
        exp_wr.push_back('{5'd7, 32'hA});
        exp_wr.push_back('{5'd7, 32'hB});
        send(6'b000010, 1'b0, 5'd7, 32'hA);
        send(6'b000010, 1'b0, 5'd7, 32'hB);
        fwd_addr = 5'd7;
        @(negedge clk);
        chk("fwd_hit_newest", fwd_hit, 1);
        chk("fwd_data_newest", fwd_data, 32'hB);
        step();
        fwd_addr = 5'd6;
        @(negedge clk);
        chk("fwd_miss_hit", fwd_hit, 0);
        chk("fwd_miss_data", fwd_data, 0);
        step();
        fwd_addr = 5'd0;
        @(negedge clk);
        chk("fwd_r0_hit", fwd_hit, 0);
        step();
        rf_grant = 1'b1;
        fwd_addr = 5'd7;
        wait_idle();
        @(negedge clk);
        chk("fwd_retired_hit", fwd_hit, 0);
        chk("fwd_retired_data", fwd_data, 0);
        step();

        // Jump behind a stalled write flushes the younger write
        rf_grant = 1'b0;
        exp_wr.push_back('{5'd2, 32'h22});
        exp_pc.push_back(32'h400);
        send(6'b000010, 1'b0, 5'd2, 32'h22);
        send(6'b100001, 1'b0, 5'd0, 32'h400);
        send(6'b000010, 1'b0, 5'd5, 32'h55);
        @(negedge clk);
        chk("jmp_pend_occupancy", occupancy, 3);
        chk("jmp_pend_pc_update", pc_update, 0);
        step();
        rf_grant = 1'b1;
        @(negedge clk);
        chk("jmp_older_wr", reg_we, 1);
        step();
        @(negedge clk);
        chk("jmp_pulse", pc_update, 1);
        chk("jmp_pulse_in_ready", in_ready, 0);
        chk("jmp_pulse_reg_we", reg_we, 0);
        step();
        @(negedge clk);
        chk("jmp_after_pulse", pc_update, 0);
        chk("jmp_after_occupancy", occupancy, 0);
        chk("jmp_after_in_ready", in_ready, 1);
        step();
        repeat (2) step();

        // Inputs that are consumed without an entry, then LDI and a taken branch
        send(6'b100000, 1'b0, 5'd1, 32'h300);
        @(negedge clk);
        chk("br_nt_occupancy", occupancy, 0);
        step();
        send(6'b110000, 1'b0, 5'd1, 32'h77);
        @(negedge clk);
        chk("nop_occupancy", occupancy, 0);
        step();
        send(6'b000010, 1'b0, 5'd0, 32'h99);
        @(negedge clk);
        chk("wr_r0_occupancy", occupancy, 0);
        step();
        exp_wr.push_back('{5'd9, 32'h77});
        send(6'b010001, 1'b0, 5'd9, 32'h77);
        @(negedge clk);
        chk("ldi_occupancy", occupancy, 1);
        step();
        wait_idle();
        exp_pc.push_back(32'h800);
        send(6'b100000, 1'b1, 5'd0, 32'h800);
        @(negedge clk);
        chk("br_taken_pulse", pc_update, 1);
        step();
        @(negedge clk);
        chk("br_taken_after", pc_update, 0);
        chk("br_taken_occupancy", occupancy, 0);
        step();

        // Reset with entries pending
        rf_grant = 1'b0;
        send(6'b000010, 1'b0, 5'd10, 32'hA0);
        send(6'b000010, 1'b0, 5'd11, 32'hA1);
        send(6'b000010, 1'b0, 5'd12, 32'hA2);
        @(negedge clk);
        chk("prerst_occupancy", occupancy, 3);
        step();
        rf_grant = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_reg_we", reg_we, 0);
        chk("midrst_in_ready", in_ready, 1);
        step();
        repeat (2) step();

        chk("wr_queue_empty", 64'(exp_wr.size()), 0);
        chk("pc_queue_empty", 64'(exp_pc.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_buf.md
# wb_commit_buf

Parametrised write-back stage with an in-order commit buffer. It accepts completed instructions from the memory stage over a valid/ready handshake and drains them one per cycle to a shared register-file write port. It also issues PC redirects for taken branches and jumps, and forwards pending register values to decode. It sits between the MEM/WB boundary and the register file / fetch PC mux, and replaces the purely combinational write-back decode.

## Interface
- DATA_W, 32, data and PC width
- REG_AW, 5, register address width
- OP_W, 6, opcode width (must be ≥ 6)
- DEPTH, 4, commit buffer entries (power of two, ≥ 2)

- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock, synchronous, active-high
- in_valid  in  1  upstream holds a completed instruction
- in_ready  out  1  buffer can accept this cycle
- in_op  in  OP_W  opcode
- in_ife  in  1  branch-condition flag from execute
- in_rd  in  REG_AW  destination register
- in_data  in  DATA_W  result value or target PC
- rf_grant  in  1  register-file write port available this cycle
- reg_we  out  1  register write strobe
- reg_waddr  out  REG_AW  write address
- reg_wdata  out  DATA_W  write data
- pc_update  out  1  one-cycle redirect pulse
- pc_new  out  DATA_W  redirect target
- fwd_addr  in  REG_AW  forwarding lookup address
- fwd_hit  out  1  a pending write to fwd_addr exists
- fwd_data  out  DATA_W  value of the newest pending write
- occupancy  out  $clog2(DEPTH)+1  valid entries

## Operation
- Classification at accept:
  - WR when op[5:4]==2'b00 or op==6'b010001.
  - BR when op==6'b100000 and in_ife=1.
  - JMP when op==6'b100001.
  - Otherwise NOP.
- Only WR, BR and JMP are enqueued. A NOP is consumed (handshake completes) without occupying an entry.
- A WR with rd==0 is enqueued as NOP-like: it is consumed and not stored.
- Accept happens when in_valid && in_ready.
- in_ready = (occupancy < DEPTH) && !pc_update. It depends only on state, so there is no combinational path from rf_grant.
- Entry fields: kind (WR/RD), rd, data. The buffer is circular with head/tail pointers that wrap modulo DEPTH.
- Head = WR:
  - reg_we = rf_grant, reg_waddr = rd, reg_wdata = data.
  - The entry pops only when rf_grant=1. Otherwise the head stalls.
- Head = redirect (BR/JMP):
  - pc_update=1, pc_new=data, independent of rf_grant.
  - Same cycle: pop head and flush all younger entries, so occupancy becomes 0.
  - Upstream flushes on the pulse. The stage itself refuses input that cycle.
- Idle outputs: reg_waddr, reg_wdata and pc_new are 0 when the corresponding strobe is low.
- Forwarding is combinational:
  - Scan valid WR entries for rd==fwd_addr; the newest (closest to tail) wins.
  - Includes the head being popped this cycle. Excludes the entry being accepted this cycle.
  - fwd_addr==0 never hits. On miss, fwd_data=0.

## Timing
- Reset: occupancy=0, pointers=0. All outputs 0 except in_ready=1.
- rst has priority over any simultaneous accept, pop or flush. Contents are discarded mid-operation.
- Latency: an instruction accepted at edge t reaches head at t+1 if the buffer was empty. Its write/redirect strobe is asserted in cycle t+1 (one-cycle minimum).
- Throughput: one accept and one pop per cycle.
- Simultaneous accept and pop: occupancy unchanged.
- Full with pop: still no accept that cycle (in_ready is registered-state based).
- The redirect pulse is exactly one cycle wide. The next cycle, in_ready=1 and occupancy=0.
- Entries behind a stalled WR head wait. A redirect never overtakes an older WR: program order is strict.

## Structure
- Package wb_pkg:
  - opcode constants OP_JMP=6'b100001, OP_BR=6'b100000, OP_LDI=6'b010001.
  - kind enum {K_WR, K_RD}.
  - function wb_classify(op, ife) returning {is_wr, is_redirect}.
- One sub-module, wb_fwd_mux: parametrised newest-match priority search over DEPTH entries, given valid mask, kinds, rds, data and head/tail pointers.
- Storage, pointers and control live in wb_commit_buf.

## Test plan
- Reset then back-to-back WR (op 6'b000010, rd 3, data 0x11; rd 4, data 0x22) with rf_grant=1 -> reg_we in cycles 1 and 2, writes (3,0x11), (4,0x22), occupancy returns 0.
- rf_grant=0 while pushing 5 WRs with DEPTH=4 -> in_ready drops after the 4th accept, occupancy=4. Then rf_grant=1 -> writes drain in order and the 5th is accepted after the first pop.
- Enqueue WR rd7=0xA, WR rd7=0xB, fwd_addr=7 -> fwd_hit=1, fwd_data=0xB. After both retire -> fwd_hit=0. fwd_addr=0 never hits.
- Enqueue JMP data 0x400 followed by WR rd5 -> pc_update pulse with pc_new=0x400 for one cycle, the WR is flushed (no reg_we for rd5), occupancy=0, in_ready low only during the pulse.
- BR op with in_ife=0, NOP op 6'b110000, WR rd0 -> all consumed, no reg_we, no pc_update, occupancy stays 0. BR with in_ife=1 -> redirect.
- Assert rst with 3 entries pending and rf_grant=1 -> next cycle occupancy=0, no reg_we, in_ready=1.
